// File: rtl/snes_dbg_hub.sv
// snes_dbg_hub: debug channel mux, masked sticky break unit and RUN/HALTED/STEP enable gate.
module snes_dbg_hub #(
    parameter int NCH  = 8,
    parameter int DW   = 8,
    parameter int CNTW = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE,
    input  logic [NCH-1:0]    DBG_SEL,
    input  logic              HUB_SEL,
    input  logic [2:0]        DBG_REG,
    input  logic              DBG_REG_WR,
    input  logic [DW-1:0]     DBG_DAT_IN,
    input  logic [NCH*DW-1:0] CH_DAT,
    input  logic [NCH-1:0]    CH_BRK,
    output logic [NCH-1:0]    CH_WR,
    output logic [DW-1:0]     DBG_DAT_OUT,
    output logic              DBG_BREAK,
    output logic              SYS_ENABLE
);
    typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd1, STEP = 2'd2} state_t;

    function automatic logic [2:0] lowest(input logic [NCH-1:0] v);
        lowest = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (v[i]) lowest = 3'(i);
    endfunction

    state_t          state, state_nxt;
    logic [NCH-1:0]  mask, status, status_nxt, brk_prev, rise, w1c;
    logic [CNTW-1:0] count;
    logic [2:0]      first, sel_idx;
    logic            halt_en, any_sel, hub_wr, ctrl_wr, step_p, resume_p;
    logic [7:0]      hub_rd;
    logic [DW-1:0]   ch_rd;

    assign sel_idx    = lowest(DBG_SEL);
    assign any_sel    = |DBG_SEL;
    assign hub_wr     = HUB_SEL & DBG_REG_WR;
    assign ctrl_wr    = hub_wr && DBG_REG == 3'd2;
    assign step_p     = ctrl_wr & DBG_DAT_IN[1];
    assign resume_p   = ctrl_wr & DBG_DAT_IN[2];
    assign rise       = CH_BRK & ~brk_prev & mask;
    assign w1c        = (hub_wr && DBG_REG == 3'd1) ? DBG_DAT_IN[NCH-1:0] : '0;
    // rise is OR'd in after the clear so a same-cycle set beats W1C
    assign status_nxt = (status & ~w1c) | rise;
    assign ch_rd      = CH_DAT[32'(sel_idx) * DW +: DW];
    assign SYS_ENABLE = !RST && state != HALTED && ENABLE;

    always_comb begin
        CH_WR = '0;
        for (int i = 0; i < NCH; i++)
            CH_WR[i] = DBG_REG_WR & ~HUB_SEL & any_sel & (sel_idx == 3'(i));
    end

    always_comb begin
        hub_rd = '0;
        case (DBG_REG)
            3'd0:    hub_rd = 8'(mask);
            3'd1:    hub_rd = 8'(status);
            3'd2:    hub_rd = {7'b0, halt_en};
            3'd3:    hub_rd = count[7:0];
            3'd4:    hub_rd = 8'(count >> 8);
            3'd5:    hub_rd = {5'b0, first};
            3'd6:    hub_rd = {6'b0, state};
            default: hub_rd = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if ((|rise && halt_en) || (ctrl_wr && DBG_DAT_IN[0] && !DBG_DAT_IN[2] && |status))
                         state_nxt = HALTED;
            HALTED:  state_nxt = resume_p ? RUN : step_p ? STEP : HALTED;
            STEP:    state_nxt = ENABLE ? HALTED : STEP;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= RUN;
        else     state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mask        <= '1;
            status      <= '0;
            count       <= '0;
            first       <= '0;
            halt_en     <= 1'b0;
            brk_prev    <= '0;
            DBG_DAT_OUT <= '0;
            DBG_BREAK   <= 1'b0;
        end else begin
            brk_prev    <= CH_BRK;
            status      <= status_nxt;
            DBG_BREAK   <= |status_nxt;
            if (|rise) count <= &count ? count : count + CNTW'(1);
            if (|rise && status == '0) first <= lowest(rise);
            if (hub_wr && DBG_REG == 3'd0) mask <= DBG_DAT_IN[NCH-1:0];
            if (ctrl_wr) halt_en <= DBG_DAT_IN[0];
            DBG_DAT_OUT <= HUB_SEL ? DW'(hub_rd) : any_sel ? ch_rd : '0;
        end
    end
endmodule

// File: tb/tb_snes_dbg_hub.sv
// tb_snes_dbg_hub: scoreboard bench for snes_dbg_hub; read expectations queue until the output cycle.
module tb_snes_dbg_hub;
    logic        CLK = 0, RST = 1, ENABLE = 1, HUB_SEL = 0, DBG_REG_WR = 0;
    logic [7:0]  DBG_SEL = 0, DBG_DAT_IN = 0, CH_BRK = 0, CH_WR, DBG_DAT_OUT;
    logic [2:0]  DBG_REG = 0;
    logic [63:0] CH_DAT;
    logic        DBG_BREAK, SYS_ENABLE;
    logic [7:0]  exp_q[$];
    string       tag_q[$];
    bit          rd_pend = 0;
    int          n_chk = 0, n_err = 0;

    snes_dbg_hub #(.NCH(8), .DW(8), .CNTW(9)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .DBG_SEL(DBG_SEL), .HUB_SEL(HUB_SEL),
        .DBG_REG(DBG_REG), .DBG_REG_WR(DBG_REG_WR), .DBG_DAT_IN(DBG_DAT_IN), .CH_DAT(CH_DAT),
        .CH_BRK(CH_BRK), .CH_WR(CH_WR), .DBG_DAT_OUT(DBG_DAT_OUT), .DBG_BREAK(DBG_BREAK),
        .SYS_ENABLE(SYS_ENABLE));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rd_pend) begin
            rd_pend = 0;
            if (exp_q.size() == 0) chk("underflow", 1, 0);
            else chk(tag_q.pop_front(), {8'h0, DBG_DAT_OUT}, {8'h0, exp_q.pop_front()});
        end
    endtask

    task automatic expect_rd(input string tag, input logic [7:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        rd_pend = 1;
    endtask

    task automatic hub_wr(input logic [2:0] r, input logic [7:0] d);
        HUB_SEL = 1; DBG_SEL = 0; DBG_REG = r; DBG_REG_WR = 1; DBG_DAT_IN = d;
        tick();
        DBG_REG_WR = 0; HUB_SEL = 0;
    endtask

    task automatic hub_rd(input logic [2:0] r, input logic [7:0] exp, input string tag);
        HUB_SEL = 1; DBG_SEL = 0; DBG_REG = r; DBG_REG_WR = 0;
        expect_rd(tag, exp);
        tick();
        HUB_SEL = 0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) CH_DAT[i*8 +: 8] = 8'hA0 + 8'(i);
        tick(); tick();
        chk("rst_sysen", SYS_ENABLE, 0);
        chk("rst_break", DBG_BREAK, 0);
        chk("rst_dout", DBG_DAT_OUT, 0);
        RST = 0;
        tick();
        chk("run_sysen", SYS_ENABLE, 1);
        hub_rd(0, 8'hFF, "rst_mask");
        hub_rd(1, 8'h00, "rst_status");
        hub_rd(3, 8'h00, "rst_count");
        hub_rd(6, 8'h00, "rst_state");
        // channel strobe priority and readback
        DBG_SEL = 8'h24; DBG_REG_WR = 1; #1;
        chk("ch_wr_prio", CH_WR, 8'h04);
        expect_rd("ch2_data", 8'hA2);
        tick();
        DBG_REG_WR = 0;
        HUB_SEL = 1; DBG_REG_WR = 1; #1;
        chk("ch_wr_hub", CH_WR, 8'h00);
        DBG_REG_WR = 0; HUB_SEL = 0;
        DBG_SEL = 8'h80; expect_rd("ch7_data", 8'hA7); tick();
        DBG_SEL = 8'h00; expect_rd("nosel_data", 8'h00); tick();
        hub_wr(0, 8'h5A);
        hub_rd(0, 8'h5A, "mask_rb");
        hub_wr(0, 8'hFF);
        hub_wr(7, 8'hAA);
        hub_rd(7, 8'h00, "reg7");
        // break capture
        chk("brk_pre", DBG_BREAK, 0);
        CH_BRK = 8'h48;
        tick();
        chk("brk_post", DBG_BREAK, 1);
        tick(); tick();
        hub_rd(1, 8'h48, "status48");
        hub_rd(3, 8'h01, "count1");
        hub_rd(5, 8'h03, "first3");
        hub_wr(1, 8'h08);
        hub_rd(1, 8'h40, "w1c");
        CH_BRK = 0;
        hub_wr(1, 8'hFF);
        hub_rd(1, 8'h00, "clr");
        chk("brk_clr", DBG_BREAK, 0);
        // mask suppression and W1C race
        hub_wr(0, 8'hFE);
        CH_BRK = 8'h01; tick();
        hub_rd(1, 8'h00, "masked");
        CH_BRK = 0; tick();
        hub_wr(0, 8'hFF);
        CH_BRK = 8'h01;
        hub_wr(1, 8'h01);
        hub_rd(1, 8'h01, "race_set");
        hub_rd(3, 8'h02, "count2");
        hub_rd(5, 8'h00, "first0");
        CH_BRK = 0;
        hub_wr(1, 8'hFF);
        // halt / step / resume
        hub_wr(2, 8'h01);
        chk("no_halt_clean", SYS_ENABLE, 1);
        hub_rd(2, 8'h01, "ctrl_rb");
        CH_BRK = 8'h02;
        #1 chk("pre_halt", SYS_ENABLE, 1);
        tick();
        chk("halted", SYS_ENABLE, 0);
        CH_BRK = 0;
        hub_rd(6, 8'h01, "st_halted");
        ENABLE = 0;
        hub_wr(2, 8'h03);
        for (int i = 0; i < 3; i++) begin
            chk("step_wait", SYS_ENABLE, 0);
            tick();
        end
        hub_rd(6, 8'h02, "st_step");
        ENABLE = 1;
        #1 chk("step_pulse", SYS_ENABLE, 1);
        tick();
        chk("step_done", SYS_ENABLE, 0);
        hub_rd(6, 8'h01, "st_rehalt");
        hub_wr(2, 8'h05);
        chk("resume", SYS_ENABLE, 1);
        hub_rd(6, 8'h00, "st_run");
        hub_wr(2, 8'h01);
        chk("ctrl_halt", SYS_ENABLE, 0);
        hub_wr(2, 8'h06);
        chk("resume_prio", SYS_ENABLE, 1);
        hub_rd(6, 8'h00, "st_run2");
        // counter saturation
        hub_wr(1, 8'hFF);
        for (int i = 0; i < 600; i++) begin
            CH_BRK = 8'h01; tick();
            CH_BRK = 8'h00; tick();
        end
        hub_rd(3, 8'hFF, "sat_lo");
        hub_rd(4, 8'h01, "sat_hi");
        // reset while halted
        hub_wr(2, 8'h01);
        chk("halt_again", SYS_ENABLE, 0);
        hub_wr(0, 8'h33);
        RST = 1;
        tick();
        chk("rst2_sysen", SYS_ENABLE, 0);
        chk("rst2_break", DBG_BREAK, 0);
        RST = 0;
        tick();
        chk("rst2_run", SYS_ENABLE, 1);
        hub_rd(6, 8'h00, "rst2_state");
        hub_rd(3, 8'h00, "rst2_count");
        hub_rd(0, 8'hFF, "rst2_mask");
        hub_rd(1, 8'h00, "rst2_status");
        hub_rd(2, 8'h00, "rst2_ctrl");
        chk("drain", 16'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
